sdram_rfifo: RTL and testbench

Synchronous read-data FIFO directly downstream of `sdram_read`. It captures `rfifo_wr_en`/`rfifo_wr_data` beats from the SDRAM read burst path and buffers them for the consumer side (UART TX / host reader). It generates the `rfifo_full` back-pressure that `sdram_read` samples before starting a burst. `rfifo_full` asserts early enough that any burst already started always fits.

---
 rtl/sdram_rfifo.sv | 98 +++++++++
 tb/tb_sdram_rfifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_rfifo.sv
`default_nettype none
// ============================================================================
// Module   : sdram_rfifo
// Purpose  : Synchronous read-data FIFO behind the SDRAM read burst path.
//            Raises rfifo_full early enough that an issued burst always fits.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_rfifo #(
  parameter int DW        = 16,
  parameter int AW        = 4,
  parameter int BURST_LEN = 4
) (
  input  logic          sclk,
  input  logic          s_rst,
  input  logic          rfifo_wr_en,
  input  logic [DW-1:0] rfifo_wr_data,
  output logic          rfifo_full,
  input  logic          rfifo_rd_en,
  output logic [DW-1:0] rfifo_rd_data,
  output logic          rfifo_rd_valid,
  output logic          rfifo_empty,
  output logic [AW:0]   rfifo_count,
  output logic          rfifo_ovf,
  output logic          rfifo_udf
);

  localparam int          DEPTH      = 1 << AW;
  localparam logic [AW:0] C_DEPTH    = (AW+1)'(DEPTH);
  // Full once free space drops below one burst: count > DEPTH - BURST_LEN.
  localparam logic [AW:0] C_FULL_THR = (AW+1)'(DEPTH - BURST_LEN);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;
  logic          r_ovf;
  logic          r_udf;

  logic          w_rd_ok;
  logic          w_wr_ok;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // alongside an accepted read (the read sees the old head word).
  assign w_rd_ok = rfifo_rd_en && (r_count != '0);
  assign w_wr_ok = rfifo_wr_en && ((r_count < C_DEPTH) || w_rd_ok);

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge sclk) begin
    if (!s_rst && w_wr_ok) begin
      r_mem[r_wr_ptr] <= rfifo_wr_data;
    end
  end

  // Pointers, occupancy, registered read port and sticky error flags.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      r_rd_valid <= w_rd_ok;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (rfifo_wr_en && !w_wr_ok) begin
        r_ovf <= 1'b1;
      end
      if (rfifo_rd_en && !w_rd_ok) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign rfifo_full     = (r_count > C_FULL_THR);
  assign rfifo_empty    = (r_count == '0);
  assign rfifo_count    = r_count;
  assign rfifo_rd_data  = r_rd_data;
  assign rfifo_rd_valid = r_rd_valid;
  assign rfifo_ovf      = r_ovf;
  assign rfifo_udf      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_rfifo
// Purpose  : Directed self-checking bench for sdram_rfifo (DEPTH 16, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_rfifo;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic        rfifo_wr_en = 1'b0;
  logic [15:0] rfifo_wr_data = '0;
  logic        rfifo_full;
  logic        rfifo_rd_en = 1'b0;
  logic [15:0] rfifo_rd_data;
  logic        rfifo_rd_valid;
  logic        rfifo_empty;
  logic [4:0]  rfifo_count;
  logic        rfifo_ovf;
  logic        rfifo_udf;

  int checks = 0;
  int errors = 0;

  sdram_rfifo #(.DW(16), .AW(4), .BURST_LEN(4)) dut (
    .sclk           (sclk),
    .s_rst          (s_rst),
    .rfifo_wr_en    (rfifo_wr_en),
    .rfifo_wr_data  (rfifo_wr_data),
    .rfifo_full     (rfifo_full),
    .rfifo_rd_en    (rfifo_rd_en),
    .rfifo_rd_data  (rfifo_rd_data),
    .rfifo_rd_valid (rfifo_rd_valid),
    .rfifo_empty    (rfifo_empty),
    .rfifo_count    (rfifo_count),
    .rfifo_ovf      (rfifo_ovf),
    .rfifo_udf      (rfifo_udf)
  );

  // 100 MHz clock.
  always #5 sclk = ~sclk;

  // Apply one cycle of inputs and sample outputs 1 ns after the edge.
  task automatic step(input logic wr, input logic [15:0] data, input logic rd);
    rfifo_wr_en   = wr;
    rfifo_wr_data = data;
    rfifo_rd_en   = rd;
    @(posedge sclk);
    #1;
    rfifo_wr_en = 1'b0;
    rfifo_rd_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] burst [4];

  initial begin
    burst[0] = 16'h0f10; burst[1] = 16'h0f55; burst[2] = 16'h0faa; burst[3] = 16'h0f01;

    // Reset held for two cycles.
    s_rst = 1'b1;
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("rst_empty", 32'(rfifo_empty), 32'd1);
    chk("rst_full", 32'(rfifo_full), 32'd0);
    chk("rst_count", 32'(rfifo_count), 32'd0);
    chk("rst_valid", 32'(rfifo_rd_valid), 32'd0);
    chk("rst_data", 32'(rfifo_rd_data), 32'd0);
    chk("rst_ovf", 32'(rfifo_ovf), 32'd0);
    chk("rst_udf", 32'(rfifo_udf), 32'd0);
    s_rst = 1'b0;

    // Burst round trip.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, burst[i], 1'b0);
      chk("burst_wr_count", 32'(rfifo_count), 32'(i + 1));
    end
    chk("burst_not_empty", 32'(rfifo_empty), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b1);
      chk("burst_valid", 32'(rfifo_rd_valid), 32'd1);
      chk("burst_data", 32'(rfifo_rd_data), 32'(burst[i]));
    end
    chk("burst_count_end", 32'(rfifo_count), 32'd0);
    chk("burst_empty_end", 32'(rfifo_empty), 32'd1);
    step(1'b0, 16'h0, 1'b0);
    chk("burst_valid_drop", 32'(rfifo_rd_valid), 32'd0);
    chk("burst_data_hold", 32'(rfifo_rd_data), 32'h0f01);

    // Full threshold at count 13.
    for (int i = 0; i < 12; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    chk("thr_full_12", 32'(rfifo_full), 32'd0);
    step(1'b1, 16'h010c, 1'b0);
    chk("thr_full_13", 32'(rfifo_full), 32'd1);
    chk("thr_count_13", 32'(rfifo_count), 32'd13);
    step(1'b0, 16'h0, 1'b1);
    chk("thr_full_rd", 32'(rfifo_full), 32'd0);
    chk("thr_rd_data", 32'(rfifo_rd_data), 32'h0100);
    chk("thr_count_12", 32'(rfifo_count), 32'd12);

    // Fill to 16, then simultaneous write and read while full.
    for (int i = 13; i < 17; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    chk("full16_count", 32'(rfifo_count), 32'd16);
    chk("full16_ovf", 32'(rfifo_ovf), 32'd0);
    step(1'b1, 16'h0bad, 1'b1);
    chk("full_rw_count", 32'(rfifo_count), 32'd16);
    chk("full_rw_data", 32'(rfifo_rd_data), 32'h0101);
    chk("full_rw_valid", 32'(rfifo_rd_valid), 32'd1);
    chk("full_rw_ovf", 32'(rfifo_ovf), 32'd0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 16'h0, 1'b1);
      chk("full_drain", 32'(rfifo_rd_data), 32'(16'h0102 + i));
    end
    step(1'b0, 16'h0, 1'b1);
    chk("full_drain_last", 32'(rfifo_rd_data), 32'h0bad);
    chk("full_drain_cnt", 32'(rfifo_count), 32'd0);

    // Read while empty.
    step(1'b0, 16'h0, 1'b1);
    chk("udf_valid", 32'(rfifo_rd_valid), 32'd0);
    chk("udf_flag", 32'(rfifo_udf), 32'd1);
    chk("udf_count", 32'(rfifo_count), 32'd0);

    // Write and read together on empty: no fall-through.
    step(1'b1, 16'h0077, 1'b1);
    chk("ft_valid", 32'(rfifo_rd_valid), 32'd0);
    chk("ft_count", 32'(rfifo_count), 32'd1);
    step(1'b0, 16'h0, 1'b1);
    chk("ft_data", 32'(rfifo_rd_data), 32'h0077);
    chk("ft_valid2", 32'(rfifo_rd_valid), 32'd1);

    // Simultaneous write and read at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0200 + i), 1'b0);
    step(1'b1, 16'h0205, 1'b1);
    chk("c5_count", 32'(rfifo_count), 32'd5);
    chk("c5_data", 32'(rfifo_rd_data), 32'h0200);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 16'h0, 1'b1);
      chk("c5_drain", 32'(rfifo_rd_data), 32'(16'h0200 + i));
    end

    // Overflow: 17 writes, the last is dropped.
    for (int i = 0; i < 17; i++) step(1'b1, 16'(i), 1'b0);
    chk("ovf_count", 32'(rfifo_count), 32'd16);
    chk("ovf_flag", 32'(rfifo_ovf), 32'd1);
    chk("ovf_full", 32'(rfifo_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 16'h0, 1'b1);
      chk("ovf_drain", 32'(rfifo_rd_data), 32'(i));
    end
    chk("ovf_drain_cnt", 32'(rfifo_count), 32'd0);
    chk("ovf_drain_empty", 32'(rfifo_empty), 32'd1);

    // 40 interleaved writes and reads across pointer wrap.
    step(1'b1, 16'h0300, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 16'(16'h0300 + i), 1'b1);
      chk("wrap_data", 32'(rfifo_rd_data), 32'(16'h0300 + i - 1));
      chk("wrap_count", 32'(rfifo_count), 32'd1);
    end
    step(1'b0, 16'h0, 1'b1);
    chk("wrap_last", 32'(rfifo_rd_data), 32'h0327);
    chk("wrap_empty", 32'(rfifo_empty), 32'd1);

    // Mid-operation reset at count 7 with overflow set.
    for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h0400 + i), 1'b0);
    chk("mrst_pre_count", 32'(rfifo_count), 32'd7);
    s_rst = 1'b1;
    step(1'b1, 16'h0abc, 1'b1);
    s_rst = 1'b0;
    chk("mrst_count", 32'(rfifo_count), 32'd0);
    chk("mrst_empty", 32'(rfifo_empty), 32'd1);
    chk("mrst_ovf", 32'(rfifo_ovf), 32'd0);
    chk("mrst_udf", 32'(rfifo_udf), 32'd0);
    chk("mrst_valid", 32'(rfifo_rd_valid), 32'd0);
    chk("mrst_data", 32'(rfifo_rd_data), 32'd0);
    step(1'b0, 16'h0, 1'b0);
    chk("mrst_post_count", 32'(rfifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
